// File: rtl/disp_req_arbiter_if.sv
// disp_req_arbiter_if
//   Bundles the three requester handshakes (operand entry, ALU result,
//   status message) and the display-decoder write bus driven by the
//   arbiter.
//   slave  modport : the arbiter (consumes requests, drives acks/display)
//   master modport : requesters + decoder side (drives requests, sees acks)
//   Signals:
//     ent_req/ent_val/ent_sgn -> ent_ack    operand-entry request
//     res_req/res_val/res_sgn/res_dot -> res_ack   ALU result request
//     err_req/err_code -> err_ack           status message request
//     display_sel, wr_enable, bin, sgn, dot, msg   decoder write bus
//     busy                                  arbiter not idle
interface disp_req_arbiter_if;
  logic       ent_req;
  logic [7:0] ent_val;
  logic       ent_sgn;
  logic       ent_ack;

  logic       res_req;
  logic [7:0] res_val;
  logic       res_sgn;
  logic [1:0] res_dot;
  logic       res_ack;

  logic       err_req;
  logic [1:0] err_code;
  logic       err_ack;

  logic       display_sel;
  logic       wr_enable;
  logic [7:0] bin;
  logic       sgn;
  logic [1:0] dot;
  logic [1:0] msg;
  logic       busy;

  modport slave (
    input  ent_req, ent_val, ent_sgn,
    input  res_req, res_val, res_sgn, res_dot,
    input  err_req, err_code,
    output ent_ack, res_ack, err_ack,
    output display_sel, wr_enable, bin, sgn, dot, msg, busy
  );

  modport master (
    output ent_req, ent_val, ent_sgn,
    output res_req, res_val, res_sgn, res_dot,
    output err_req, err_code,
    input  ent_ack, res_ack, err_ack,
    input  display_sel, wr_enable, bin, sgn, dot, msg, busy
  );
endinterface

// File: rtl/disp_req_arbiter.sv
// disp_req_arbiter
//   Shares the 4-digit 7-segment display writer between the operand-entry,
//   ALU-result and status-message requesters (priority err > res > ent).
//   Numeric writes are one-cycle strobes; status messages are held for
//   MSG_HOLD cycles after which the last numeric value is rewritten.
//   Ports:
//     clk  : system clock
//     rst  : asynchronous active-high reset
//     bus  : request handshakes and decoder write bus (slave modport)
//   All outputs are registered.
module disp_req_arbiter #(
  parameter int MSG_HOLD = 50000000,
  parameter int CW       = 26
) (
  input  logic                clk,
  input  logic                rst,
  disp_req_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, WR, HOLD, RESTORE} state_t;

  localparam logic [CW-1:0] HOLD_LOAD = CW'(MSG_HOLD - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic       ent_ack_q, ent_ack_d;
  logic       res_ack_q, res_ack_d;
  logic       err_ack_q, err_ack_d;
  logic       sel_q, sel_d;
  logic       wr_q, wr_d;
  logic [7:0] bin_q, bin_d;
  logic       sgn_q, sgn_d;
  logic [1:0] dot_q, dot_d;
  logic [1:0] msg_q, msg_d;
  logic       busy_q, busy_d;

  // Last numeric value written, rewritten when a message expires.
  logic [7:0] sh_val_q, sh_val_d;
  logic       sh_sgn_q, sh_sgn_d;
  logic [1:0] sh_dot_q, sh_dot_d;

  logic err_valid;
  assign err_valid = bus.err_req && (bus.err_code != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ent_ack_q <= 1'b0;
      res_ack_q <= 1'b0;
      err_ack_q <= 1'b0;
      sel_q     <= 1'b0;
      wr_q      <= 1'b0;
      bin_q     <= '0;
      sgn_q     <= 1'b0;
      dot_q     <= '0;
      msg_q     <= '0;
      busy_q    <= 1'b0;
      sh_val_q  <= '0;
      sh_sgn_q  <= 1'b0;
      sh_dot_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ent_ack_q <= ent_ack_d;
      res_ack_q <= res_ack_d;
      err_ack_q <= err_ack_d;
      sel_q     <= sel_d;
      wr_q      <= wr_d;
      bin_q     <= bin_d;
      sgn_q     <= sgn_d;
      dot_q     <= dot_d;
      msg_q     <= msg_d;
      busy_q    <= busy_d;
      sh_val_q  <= sh_val_d;
      sh_sgn_q  <= sh_sgn_d;
      sh_dot_q  <= sh_dot_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ent_ack_d = 1'b0;
    res_ack_d = 1'b0;
    err_ack_d = 1'b0;
    sel_d     = 1'b0;
    wr_d      = 1'b0;
    bin_d     = bin_q;
    sgn_d     = sgn_q;
    dot_d     = dot_q;
    msg_d     = msg_q;
    sh_val_d  = sh_val_q;
    sh_sgn_d  = sh_sgn_q;
    sh_dot_d  = sh_dot_q;

    case (state_q)
      IDLE: begin
        // An err_req always takes the cycle, even with an invalid code:
        // it is acknowledged so the requester can drop it, then dropped.
        if (bus.err_req) begin
          err_ack_d = 1'b1;
          if (err_valid) begin
            msg_d   = bus.err_code;
            cnt_d   = HOLD_LOAD;
            state_d = HOLD;
          end
        end else if (bus.res_req) begin
          res_ack_d = 1'b1;
          sel_d     = 1'b1;
          wr_d      = 1'b1;
          bin_d     = bus.res_val;
          sgn_d     = bus.res_sgn;
          dot_d     = bus.res_dot;
          sh_val_d  = bus.res_val;
          sh_sgn_d  = bus.res_sgn;
          sh_dot_d  = bus.res_dot;
          state_d   = WR;
        end else if (bus.ent_req) begin
          ent_ack_d = 1'b1;
          sel_d     = 1'b1;
          wr_d      = 1'b1;
          bin_d     = bus.ent_val;
          sgn_d     = bus.ent_sgn;
          dot_d     = 2'b00;
          sh_val_d  = bus.ent_val;
          sh_sgn_d  = bus.ent_sgn;
          sh_dot_d  = 2'b00;
          state_d   = WR;
        end
      end

      // Gap cycle after a write: guarantees two-cycle accept spacing.
      WR: state_d = IDLE;

      HOLD: begin
        if (err_valid) begin
          // New message restarts the full hold period.
          err_ack_d = 1'b1;
          msg_d     = bus.err_code;
          cnt_d     = HOLD_LOAD;
        end else begin
          // Invalid codes are acked and ignored; the hold keeps running.
          err_ack_d = bus.err_req;
          if (cnt_q == '0) begin
            msg_d   = 2'b00;
            bin_d   = sh_val_q;
            sgn_d   = sh_sgn_q;
            dot_d   = sh_dot_q;
            sel_d   = 1'b1;
            wr_d    = 1'b1;
            state_d = RESTORE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end

      RESTORE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.ent_ack     = ent_ack_q;
  assign bus.res_ack     = res_ack_q;
  assign bus.err_ack     = err_ack_q;
  assign bus.display_sel = sel_q;
  assign bus.wr_enable   = wr_q;
  assign bus.bin         = bin_q;
  assign bus.sgn         = sgn_q;
  assign bus.dot         = dot_q;
  assign bus.msg         = msg_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_disp_req_arbiter.sv
module tb_disp_req_arbiter;
  localparam int MH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  disp_req_arbiter_if bus ();

  disp_req_arbiter #(.MSG_HOLD(MH), .CW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: edge timestamps instead of states.
  //   msg_end : edge index at which the current message gets replaced by
  //             the restored numeric value (0 = no message showing)
  //   free_at : first edge index at which a request can be accepted
  int n = 0;
  int free_at = 0;
  int msg_end = 0;
  logic [2:0] e_ack;   // {err, res, ent}
  logic       e_sel, e_wr, e_sgn, e_busy;
  logic [7:0] e_bin;
  logic [1:0] e_dot, e_msg;
  logic [7:0] m_val;
  logic       m_sgn;
  logic [1:0] m_dot;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    free_at = 0; msg_end = 0;
    e_ack = '0; e_sel = 0; e_wr = 0; e_sgn = 0; e_busy = 0;
    e_bin = '0; e_dot = '0; e_msg = '0;
    m_val = '0; m_sgn = 0; m_dot = '0;
  endtask

  task automatic show_number(input logic [7:0] v, input logic s, input logic [1:0] d);
    e_sel = 1; e_wr = 1; e_bin = v; e_sgn = s; e_dot = d;
  endtask

  task automatic model_edge();
    logic valid;
    n++;
    e_ack = '0; e_sel = 0; e_wr = 0;
    valid = bus.err_req && (bus.err_code != 2'b00);
    if (msg_end != 0) begin
      if (bus.err_req) e_ack = 3'b100;
      if (valid) begin
        e_msg = bus.err_code;
        msg_end = n + MH;
      end else if (n == msg_end) begin
        e_msg = 2'b00;
        show_number(m_val, m_sgn, m_dot);
        msg_end = 0;
        free_at = n + 2;
      end
    end else if (n >= free_at) begin
      if (bus.err_req) begin
        e_ack = 3'b100;
        if (valid) begin
          e_msg = bus.err_code;
          msg_end = n + MH;
        end
      end else if (bus.res_req) begin
        e_ack = 3'b010;
        show_number(bus.res_val, bus.res_sgn, bus.res_dot);
        m_val = bus.res_val; m_sgn = bus.res_sgn; m_dot = bus.res_dot;
        free_at = n + 2;
      end else if (bus.ent_req) begin
        e_ack = 3'b001;
        show_number(bus.ent_val, bus.ent_sgn, 2'b00);
        m_val = bus.ent_val; m_sgn = bus.ent_sgn; m_dot = 2'b00;
        free_at = n + 2;
      end
    end
    e_busy = (msg_end != 0) || (n + 1 < free_at);
  endtask

  task automatic compare_all();
    check("acks", {bus.err_ack, bus.res_ack, bus.ent_ack}, e_ack);
    check("display_sel", bus.display_sel, e_sel);
    check("wr_enable", bus.wr_enable, e_wr);
    check("bin", bus.bin, e_bin);
    check("sgn", bus.sgn, e_sgn);
    check("dot", bus.dot, e_dot);
    check("msg", bus.msg, e_msg);
    check("busy", bus.busy, e_busy);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    bus.ent_req = 0; bus.res_req = 0; bus.err_req = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    bus.ent_val = '0; bus.ent_sgn = 0;
    bus.res_val = '0; bus.res_sgn = 0; bus.res_dot = '0;
    bus.err_code = '0;
    model_reset();
    #2;
    compare_all();
    check("rst_busy", bus.busy, 0);
    #10 rst = 1'b0;

    // Operand entry write
    bus.ent_req = 1; bus.ent_val = 8'd37; bus.ent_sgn = 1;
    step();
    check("s1_ent_ack", bus.ent_ack, 1);
    check("s1_wr", bus.wr_enable, 1);
    check("s1_sel", bus.display_sel, 1);
    check("s1_bin", bus.bin, 37);
    check("s1_sgn", bus.sgn, 1);
    check("s1_dot", bus.dot, 0);
    check("s1_msg", bus.msg, 0);
    bus.ent_req = 0;
    step();
    check("s1_wr_drop", bus.wr_enable, 0);
    check("s1_busy", bus.busy, 0);

    // Result beats entry, entry served two cycles later
    bus.res_req = 1; bus.res_val = 8'd200; bus.res_sgn = 0; bus.res_dot = 2'd2;
    bus.ent_req = 1; bus.ent_val = 8'd9; bus.ent_sgn = 0;
    step();
    check("s2_res_ack", bus.res_ack, 1);
    check("s2_ent_ack0", bus.ent_ack, 0);
    check("s2_bin", bus.bin, 200);
    check("s2_dot", bus.dot, 2);
    bus.res_req = 0;
    step();
    check("s2_gap", {bus.res_ack, bus.ent_ack}, 0);
    step();
    check("s2_ent_ack", bus.ent_ack, 1);
    check("s2_ent_bin", bus.bin, 9);
    check("s2_ent_dot", bus.dot, 0);
    bus.ent_req = 0;
    step();

    // Message hold with stalled result request, then restore
    bus.res_req = 1; bus.res_val = 8'd5; bus.res_sgn = 0; bus.res_dot = 2'd0;
    step();
    check("s3_res_ack", bus.res_ack, 1);
    bus.res_req = 0;
    step();
    bus.err_req = 1; bus.err_code = 2'b11;
    bus.res_req = 1; bus.res_val = 8'd77;
    step();
    check("s3_err_ack", bus.err_ack, 1);
    check("s3_msg", bus.msg, 3);
    check("s3_no_wr", bus.wr_enable, 0);
    bus.err_req = 0;
    for (int i = 0; i < MH - 1; i++) begin
      step();
      check("s3_msg_held", bus.msg, 3);
      check("s3_stalled", bus.res_ack, 0);
    end
    step();
    check("s3_restore_wr", bus.wr_enable, 1);
    check("s3_restore_bin", bus.bin, 5);
    check("s3_restore_msg", bus.msg, 0);
    check("s3_restore_noack", bus.res_ack, 0);
    step();
    check("s3_post_restore", {bus.res_ack, bus.wr_enable}, 0);
    step();
    check("s3_res_served", bus.res_ack, 1);
    check("s3_res_bin", bus.bin, 77);
    bus.res_req = 0;
    step();

    // Message restart three cycles into the hold
    bus.err_req = 1; bus.err_code = 2'b01;
    step();
    check("s4_msg1", bus.msg, 1);
    bus.err_req = 0;
    step();
    step();
    bus.err_req = 1; bus.err_code = 2'b10;
    step();
    check("s4_reack", bus.err_ack, 1);
    check("s4_msg2", bus.msg, 2);
    bus.err_req = 0;
    for (int i = 0; i < MH - 1; i++) begin
      step();
      check("s4_msg2_held", bus.msg, 2);
    end
    step();
    check("s4_restore_msg", bus.msg, 0);
    check("s4_restore_wr", bus.wr_enable, 1);
    step();
    step();

    // Invalid message code
    bus.err_req = 1; bus.err_code = 2'b00;
    step();
    check("s5_err_ack", bus.err_ack, 1);
    check("s5_msg", bus.msg, 0);
    check("s5_busy", bus.busy, 0);
    bus.err_req = 0;
    step();
    check("s5_no_wr", bus.wr_enable, 0);
    check("s5_busy2", bus.busy, 0);

    // Asynchronous reset in the middle of a hold
    bus.err_req = 1; bus.err_code = 2'b11;
    step();
    bus.err_req = 0;
    step();
    step();
    check("s6_msg_before", bus.msg, 3);
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("s6_msg", bus.msg, 0);
    check("s6_bin", bus.bin, 0);
    #1 rst = 1'b0;
    bus.ent_req = 1; bus.ent_val = 8'd37; bus.ent_sgn = 1;
    step();
    check("s6_ent_ack", bus.ent_ack, 1);
    check("s6_bin37", bus.bin, 37);
    check("s6_wr", bus.wr_enable, 1);
    bus.ent_req = 0;
    step();

    // Randomized traffic against the timestamp model
    for (int i = 0; i < 400; i++) begin
      if (bus.ent_req) begin
        if (bus.ent_ack) bus.ent_req = ($urandom_range(3) == 0);
      end else if ($urandom_range(4) == 0) begin
        bus.ent_req = 1; bus.ent_val = 8'($urandom); bus.ent_sgn = 1'($urandom);
      end
      if (bus.res_req) begin
        if (bus.res_ack) bus.res_req = ($urandom_range(3) == 0);
      end else if ($urandom_range(4) == 0) begin
        bus.res_req = 1; bus.res_val = 8'($urandom); bus.res_sgn = 1'($urandom);
        bus.res_dot = 2'($urandom);
      end
      if (bus.err_req) begin
        if (bus.err_ack) bus.err_req = ($urandom_range(5) == 0);
      end else if ($urandom_range(15) == 0) begin
        bus.err_req = 1; bus.err_code = 2'($urandom);
      end
      step();
    end
    idle_inputs();
    for (int i = 0; i < 2 * MH; i++) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
